// File: rtl/t_ff_count_sequencer.sv
// t_ff_count_sequencer: drives a WIDTH-bit bank of T flip-flops as a
// programmable up/down counter with start/stop/pause/done sequencing.
// Optional macro TSEQ_PRESCALE_EN: when defined, the count advances only
// once every PRESCALE cycles while running. When it is undefined, every
// RUN cycle advances and PRESCALE is unused.
//
// state | meaning
// IDLE  | waiting for start; limit/dir sampled here
// RUN   | bank advancing toward the latched target
// PAUSE | run suspended by stop; q, lim_r and dir_r frozen
// DONE  | one-cycle completion pulse, then back to IDLE

module t_ff_count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lim_r;
    logic             dir_r;
    logic [WIDTH-1:0] tgt;
    logic             at_tgt;
    logic             tick;
    logic             adv;

`ifdef TSEQ_PRESCALE_EN
    localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PCW-1:0] pc;

    assign tick = (pc == PCW'(PRESCALE - 1));

    // Prescale counter: free-runs in RUN, restarts at each start and pause.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else if (state == IDLE && start) begin
            pc <= '0;
        end else if (state == RUN) begin
            if (stop)
                pc <= '0;
            else if (tick)
                pc <= '0;
            else
                pc <= pc + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign tgt    = dir_r ? '0 : lim_r;
    assign at_tgt = (q == tgt);
    // Reset gating keeps the enable vector quiet while the bank is being cleared.
    assign adv    = !reset && (state == RUN) && !stop && tick && !at_tgt;

    // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        t_vec = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_vec[i] = adv & carry;
            carry    = carry & (dir_r ? ~q[i] : q[i]);
        end
    end

    // Sequencer FSM with registered bank state and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            lim_r <= '0;
            dir_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lim_r <= limit;
                        dir_r <= dir;
                        q     <= dir ? limit : '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= PAUSE;
                    end else if (tick && at_tgt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        q <= q ^ t_vec;
                    end
                end
                PAUSE: begin
                    if (start && !stop)
                        state <= RUN;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_ff_count_sequencer.sv
// Directed bench for t_ff_count_sequencer (WIDTH=4, PRESCALE=4).
// Inputs change and outputs are sampled 1 time unit after a rising edge.

module tb_t_ff_count_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stop, dir;
    logic [3:0] limit;
    logic [3:0] t_vec, q;
    logic       busy, done;

    int n_cmp = 0;
    int n_err = 0;

    t_ff_count_sequencer #(.WIDTH(4), .PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .limit (limit),
        .t_vec (t_vec),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // settle combinational t_vec after an input change, then compare
    task automatic chk_tv(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, {12'h0, t_vec}, {12'h0, exp});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, {15'h0, done}, 16'h1);
    endtask

    initial begin
        logic [3:0] down_exp [4];
        down_exp[0] = 4'd3; down_exp[1] = 4'd2; down_exp[2] = 4'd1; down_exp[3] = 4'd0;

        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; limit = 4'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_q",    {12'h0, q}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_done", {15'h0, done}, 16'h0);
        chk_tv("rst_tvec", 4'b0000);

`ifdef TSEQ_PRESCALE_EN
        // q steps on k+4 and k+8, done on the following tick (k+12)
        start = 1'b1; dir = 1'b0; limit = 4'd2;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c < 4)       chk("ps_q0", {12'h0, q}, 16'd0);
            else if (c < 8)  chk("ps_q1", {12'h0, q}, 16'd1);
            else             chk("ps_q2", {12'h0, q}, 16'd2);
            chk("ps_done", {15'h0, done}, (c == 12) ? 16'h1 : 16'h0);
        end
        step();
        chk("ps_idle_busy", {15'h0, busy}, 16'h0);
`else
        // up count to 3
        start = 1'b1; dir = 1'b0; limit = 4'd3;
        step();
        start = 1'b0;
        chk("up_busy", {15'h0, busy}, 16'h1);
        chk("up_q0", {12'h0, q}, 16'd0);
        chk_tv("up_tv0", 4'b0001);
        step();
        chk("up_q1", {12'h0, q}, 16'd1);
        chk_tv("up_tv1", 4'b0011);
        step();
        chk("up_q2", {12'h0, q}, 16'd2);
        chk_tv("up_tv2", 4'b0001);
        step();
        chk("up_q3", {12'h0, q}, 16'd3);
        chk("up_done_early", {15'h0, done}, 16'h0);
        chk_tv("up_tv3", 4'b0000);
        step();
        chk("up_done", {15'h0, done}, 16'h1);
        chk("up_done_busy", {15'h0, busy}, 16'h0);
        chk("up_done_q", {12'h0, q}, 16'd3);
        step();
        chk("up_done_clr", {15'h0, done}, 16'h0);
        chk("up_idle_q", {12'h0, q}, 16'd3);

        // down count from 4
        start = 1'b1; dir = 1'b1; limit = 4'd4;
        step();
        start = 1'b0;
        chk("dn_q4", {12'h0, q}, 16'd4);
        chk_tv("dn_tv4", 4'b0111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dn_q", {12'h0, q}, {12'h0, down_exp[i]});
        end
        chk("dn_done_early", {15'h0, done}, 16'h0);
        step();
        chk("dn_done", {15'h0, done}, 16'h1);
        chk("dn_done_q", {12'h0, q}, 16'd0);
        step();
        chk("dn_done_clr", {15'h0, done}, 16'h0);

        // pause and resume
        start = 1'b1; dir = 1'b0; limit = 4'd10;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pz_q4", {12'h0, q}, 16'd4);
        stop = 1'b1;
        chk_tv("pz_tv_stop", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pz_hold_q", {12'h0, q}, 16'd4);
            chk("pz_busy", {15'h0, busy}, 16'h1);
            chk_tv("pz_tv", 4'b0000);
        end
        stop = 1'b0; start = 1'b1;
        chk_tv("pz_tv_resume", 4'b0000);
        step();
        start = 1'b0;
        chk("pz_resume_q", {12'h0, q}, 16'd4);
        step();
        chk("pz_q5", {12'h0, q}, 16'd5);
        start = 1'b1; stop = 1'b1;
        chk_tv("pz_both_tv", 4'b0000);
        step();
        chk("pz_both_q", {12'h0, q}, 16'd5);
        step();
        chk("pz_both_hold", {12'h0, q}, 16'd5);
        stop = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("pz_q6", {12'h0, q}, 16'd6);
        wait_done(20, "pz");
        chk("pz_final_q", {12'h0, q}, 16'd10);
        step();

        // limit 0, both directions: done with no toggles
        start = 1'b1; dir = 1'b0; limit = 4'd0;
        step();
        start = 1'b0;
        chk_tv("z_up_tv", 4'b0000);
        step();
        chk("z_up_done", {15'h0, done}, 16'h1);
        chk("z_up_q", {12'h0, q}, 16'd0);
        step();
        start = 1'b1; dir = 1'b1; limit = 4'd0;
        step();
        start = 1'b0;
        chk_tv("z_dn_tv", 4'b0000);
        step();
        chk("z_dn_done", {15'h0, done}, 16'h1);
        step();

        // limit/dir changes mid-run are ignored
        start = 1'b1; dir = 1'b0; limit = 4'd6;
        step();
        start = 1'b0;
        step();
        limit = 4'd2; dir = 1'b1;
        wait_done(20, "lim");
        chk("lim_final_q", {12'h0, q}, 16'd6);
        step();

        // stop is ignored in IDLE, including alongside start
        stop = 1'b1;
        step();
        chk("idle_stop_busy", {15'h0, busy}, 16'h0);
        start = 1'b1; dir = 1'b0; limit = 4'd1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("idle_ss_busy", {15'h0, busy}, 16'h1);
        step();
        chk("idle_ss_q1", {12'h0, q}, 16'd1);
        step();
        chk("idle_ss_done", {15'h0, done}, 16'h1);
        step();
`endif

        // reset in the middle of a run
        start = 1'b1; dir = 1'b0; limit = 4'd5;
        step();
        start = 1'b0;
        step(); step();
        reset = 1'b1;
        chk_tv("mr_tv", 4'b0000);
        step();
        reset = 1'b0;
        chk("mr_q", {12'h0, q}, 16'd0);
        chk("mr_busy", {15'h0, busy}, 16'h0);
        chk("mr_done", {15'h0, done}, 16'h0);
        step();
        chk("mr_idle_q", {12'h0, q}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
